// File: rtl/sub_mp_seq.sv
// Multi-precision subtraction sequencer: Y = A - B over LIMBS limbs of N bits, one limb per clock, LSB first.
// Optional build macro SUB_MP_SEQ_SAT_EN clamps an underflowing result to zero.
module sub_mp_seq #(
  parameter int N     = 8,
  parameter int LIMBS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N*LIMBS-1:0] a,
  input  logic [N*LIMBS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [N*LIMBS-1:0] y,
  output logic               borrow,
  output logic               zero
);

  localparam int W    = N * LIMBS;
  localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LIMBS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            wb_q, wb_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    y_q, y_d;
  logic            borrow_q, borrow_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic [N-1:0]    a_limb_s;
  logic [N-1:0]    b_limb_s;
  logic [N:0]      diff_s;

  // Next-state logic: operand capture in IDLE, one limb of subtract-with-borrow per RUN cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wb_d     = wb_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    y_d      = y_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    a_limb_s = a_q[idx_q*N +: N];
    b_limb_s = b_q[idx_q*N +: N];
    // Bit N of the (N+1)-bit difference is the borrow out of this limb.
    diff_s   = {1'b0, a_limb_s} - {1'b0, b_limb_s} - {{N{1'b0}}, wb_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          wb_d    = 1'b0;
          idx_d   = IDX_ZERO;
          work_d  = {W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[idx_q*N +: N] = diff_s[N-1:0];
        wb_d                 = diff_s[N];
        if (idx_q == IDX_LAST) begin
`ifdef SUB_MP_SEQ_SAT_EN
          if (diff_s[N]) begin
            y_d = {W{1'b0}};
          end else begin
            y_d = work_d;
          end
`else
          y_d = work_d;
`endif
          borrow_d = diff_s[N];
          zero_d   = (y_d == {W{1'b0}});
          done_d   = 1'b1;
          idx_d    = IDX_ZERO;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, working and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= IDX_ZERO;
      wb_q     <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      work_q   <= {W{1'b0}};
      y_q      <= {W{1'b0}};
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wb_q     <= wb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign y      = y_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule
